// File: rtl/histogram_controller.sv
// histogram_controller: sequences one histogram pass on the gray-level
// histogram RAM (clear sweep, frame accumulation, drain, ordered readout).
// Build option: define HISTCTRL_CDF_EN to stream a running cumulative sum
// on oBinData instead of the raw bin count.
//
// RAM timing assumed: address registered one cycle after it is presented,
// clear applies to that registered address, read data returns two cycles
// after the address, and an increment lands two cycles after oHistInc.
//
// Handshake: no backpressure anywhere. iStart/iFrameEnd are single-cycle
// pulses; oBinValid qualifies oBinAddr/oBinData for exactly one cycle per
// bin and the consumer must accept every valid cycle.
module histogram_controller #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 8,
    parameter int SUM_WIDTH  = 28
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iStart,
    input  logic                  iPixValid,
    input  logic [ADDR_WIDTH-1:0] iPixGray,
    input  logic                  iFrameEnd,
    output logic [ADDR_WIDTH-1:0] oHistGray,
    output logic                  oHistInc,
    output logic                  oHistClear,
    input  logic [DATA_WIDTH-1:0] iHistData,
    output logic                  oBinValid,
    output logic [ADDR_WIDTH-1:0] oBinAddr,
    output logic [SUM_WIDTH-1:0]  oBinData,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [2:0]            oDbgState
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        DRAIN = 3'd3,
        READ  = 3'd4,
        DONE  = 3'd5
    } stateT;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    stateT                 state;
    logic [1:0]            drainCnt;
    logic                  rdIssue;     // oHistGray currently carries a read address
    logic                  rdVld0;
    logic                  rdVld1;
    logic [ADDR_WIDTH-1:0] rdAddr0;
    logic [ADDR_WIDTH-1:0] rdAddr1;
    logic [SUM_WIDTH-1:0]  binValue;

    assign oDbgState = state;

    // Pass sequencer: owns the RAM address, clear/increment strobes and status.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state      <= IDLE;
            oHistGray  <= '0;
            oHistInc   <= 1'b0;
            oHistClear <= 1'b0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            drainCnt   <= 2'd0;
            rdIssue    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oHistInc   <= 1'b0;
                    oHistClear <= 1'b0;
                    oDone      <= 1'b0;
                    if (iStart) begin
                        state     <= CLEAR;
                        oHistGray <= '0;
                        oBusy     <= 1'b1;
                    end
                end
                CLEAR: begin
                    // Clear trails its address by one cycle, so it stays high
                    // for the first ACCUM cycle to cover the last address.
                    oHistClear <= 1'b1;
                    oHistInc   <= 1'b0;
                    if (oHistGray == LAST_ADDR) begin
                        state <= ACCUM;
                    end else begin
                        oHistGray <= oHistGray + 1'b1;
                    end
                end
                ACCUM: begin
                    oHistClear <= 1'b0;
                    oHistGray  <= iPixGray;
                    oHistInc   <= iPixValid;
                    if (iFrameEnd) begin
                        state    <= DRAIN;
                        drainCnt <= 2'd0;
                    end
                end
                DRAIN: begin
                    // Three idle cycles let the last increments retire in the RAM.
                    oHistInc <= 1'b0;
                    if (drainCnt == 2'd2) begin
                        state     <= READ;
                        oHistGray <= '0;
                        rdIssue   <= 1'b1;
                    end else begin
                        drainCnt <= drainCnt + 2'd1;
                    end
                end
                READ: begin
                    if (rdIssue) begin
                        if (oHistGray == LAST_ADDR) begin
                            rdIssue <= 1'b0;
                        end else begin
                            oHistGray <= oHistGray + 1'b1;
                        end
                    end
                    if (oBinValid && (oBinAddr == LAST_ADDR)) begin
                        state <= DONE;
                        oDone <= 1'b1;
                    end
                end
                DONE: begin
                    oDone <= 1'b0;
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

`ifdef HISTCTRL_CDF_EN
    logic [SUM_WIDTH-1:0] cdfSum;

    // Running sum of the bins already streamed; zero outside READ.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            cdfSum <= '0;
        end else if (state != READ) begin
            cdfSum <= '0;
        end else if (rdVld1) begin
            cdfSum <= cdfSum + SUM_WIDTH'(iHistData);
        end
    end

    assign binValue = cdfSum + SUM_WIDTH'(iHistData);
`else
    assign binValue = SUM_WIDTH'(iHistData);
`endif

    // Two-stage shadow of read valid/address, aligned with RAM read latency.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rdVld0    <= 1'b0;
            rdVld1    <= 1'b0;
            rdAddr0   <= '0;
            rdAddr1   <= '0;
            oBinValid <= 1'b0;
            oBinAddr  <= '0;
            oBinData  <= '0;
        end else begin
            rdVld0    <= rdIssue;
            rdAddr0   <= oHistGray;
            rdVld1    <= rdVld0;
            rdAddr1   <= rdAddr0;
            oBinValid <= rdVld1;
            if (rdVld1) begin
                oBinAddr <= rdAddr1;
                oBinData <= binValue;
            end
        end
    end

endmodule
